// File: rtl/id_stage_pkg.sv
// Shared encodings and types for the instruction-decode stage.
package id_stage_pkg;

    // Execute-unit operation codes
    typedef enum logic [3:0] {
        CmdNop = 4'b0000,
        CmdMov = 4'b0001,
        CmdAdd = 4'b0010,
        CmdAdc = 4'b0011,
        CmdSub = 4'b0100,
        CmdSbc = 4'b0101,
        CmdAnd = 4'b0110,
        CmdOrr = 4'b0111,
        CmdEor = 4'b1000,
        CmdMvn = 4'b1001
    } exe_cmd_e;

    // Instruction class in bits [27:26]
    typedef enum logic [1:0] {
        ModeArith  = 2'b00,
        ModeMem    = 2'b01,
        ModeBranch = 2'b10
    } mode_e;

    // Condition field in bits [31:28]
    typedef enum logic [3:0] {
        CondEq = 4'b0000,
        CondNe = 4'b0001,
        CondCs = 4'b0010,
        CondCc = 4'b0011,
        CondMi = 4'b0100,
        CondPl = 4'b0101,
        CondVs = 4'b0110,
        CondVc = 4'b0111,
        CondHi = 4'b1000,
        CondLs = 4'b1001,
        CondGe = 4'b1010,
        CondLt = 4'b1011,
        CondGt = 4'b1100,
        CondLe = 4'b1101,
        CondAl = 4'b1110
    } cond_e;

    // Data-processing opcodes in bits [24:21]
    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpEor = 4'b0001;
    localparam logic [3:0] OpSub = 4'b0010;
    localparam logic [3:0] OpAdd = 4'b0100;
    localparam logic [3:0] OpAdc = 4'b0101;
    localparam logic [3:0] OpSbc = 4'b0110;
    localparam logic [3:0] OpTst = 4'b1000;
    localparam logic [3:0] OpCmp = 4'b1010;
    localparam logic [3:0] OpOrr = 4'b1100;
    localparam logic [3:0] OpMov = 4'b1101;
    localparam logic [3:0] OpMvn = 4'b1111;

    typedef struct packed {
        logic     wb_en;
        logic     mem_r_en;
        logic     mem_w_en;
        logic     b;
        logic     s;
        logic     imm;
        exe_cmd_e exe_cmd;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic [3:0]  dest;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        ctrl_t       ctrl;
    } id_out_t;

    // Evaluate cond against flags {N,Z,C,V}; the unused code 1111 never executes.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] sr);
        logic n, z, c, v, ok;
        {n, z, c, v} = sr;
        case (cond_e'(cond))
            CondEq:  ok = z;
            CondNe:  ok = ~z;
            CondCs:  ok = c;
            CondCc:  ok = ~c;
            CondMi:  ok = n;
            CondPl:  ok = ~n;
            CondVs:  ok = v;
            CondVc:  ok = ~v;
            CondHi:  ok = c & ~z;
            CondLs:  ok = ~c | z;
            CondGe:  ok = (n == v);
            CondLt:  ok = (n != v);
            CondGt:  ok = ~z & (n == v);
            CondLe:  ok = z | (n != v);
            CondAl:  ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/register_file.sv
// 16x32 register file: synchronous write, combinational read with write-through.
module register_file
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src1_i,
    input  logic [3:0]  src2_i,
    input  logic        wr_en_i,
    input  logic [3:0]  wr_dest_i,
    input  logic [31:0] wr_value_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);

    logic [15:0][31:0] regs_q, regs_d;

    // Next register contents from the write port
    always_comb begin
        regs_d = regs_q;
        if (wr_en_i) begin
            regs_d[wr_dest_i] = wr_value_i;
        end
    end

    // Storage update; reset clears every register
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads see a same-cycle write so the writeback stage needs no extra bypass
    always_comb begin
        rd1_o = (wr_en_i && wr_dest_i == src1_i) ? wr_value_i : regs_q[src1_i];
        rd2_o = (wr_en_i && wr_dest_i == src2_i) ? wr_value_i : regs_q[src2_i];
    end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: decode, condition check, hazard detection, ID/EX register.
module id_stage
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_in,
    input  logic [31:0] Instruction,
    input  logic        flush,
    input  logic [3:0]  SR,
    input  logic        WB_WB_EN,
    input  logic [3:0]  WB_Dest,
    input  logic [31:0] WB_Value,
    input  logic        EXE_WB_EN,
    input  logic [3:0]  EXE_Dest,
    input  logic        MEM_WB_EN,
    input  logic [3:0]  MEM_Dest,
    output logic        hazard,
    output logic [31:0] PC,
    output logic [31:0] Val_Rn,
    output logic [31:0] Val_Rm,
    output logic [3:0]  Dest,
    output logic [3:0]  EXE_CMD,
    output logic [11:0] Shift_operand,
    output logic [23:0] Signed_imm_24,
    output logic        WB_EN,
    output logic        MEM_R_EN,
    output logic        MEM_W_EN,
    output logic        B,
    output logic        S,
    output logic        Imm
);

    mode_e       mode;
    logic [3:0]  opcode, rn, rd, rm, src2;
    logic        i_bit, s_bit, two_src;
    ctrl_t       ctrl, ctrl_g;
    logic [31:0] val_rn, val_rm;
    id_out_t     out_q, out_d;

    assign mode   = mode_e'(Instruction[27:26]);
    assign i_bit  = Instruction[25];
    assign opcode = Instruction[24:21];
    assign s_bit  = Instruction[20];
    assign rn     = Instruction[19:16];
    assign rd     = Instruction[15:12];
    assign rm     = Instruction[3:0];

    // Control decode; any unlisted mode or opcode yields an all-zero NOP
    always_comb begin
        ctrl = '0;
        case (mode)
            ModeArith: begin
                ctrl.wb_en = 1'b1;
                ctrl.s     = s_bit;
                ctrl.imm   = i_bit;
                case (opcode)
                    OpMov:   ctrl.exe_cmd = CmdMov;
                    OpMvn:   ctrl.exe_cmd = CmdMvn;
                    OpAdd:   ctrl.exe_cmd = CmdAdd;
                    OpAdc:   ctrl.exe_cmd = CmdAdc;
                    OpSub:   ctrl.exe_cmd = CmdSub;
                    OpSbc:   ctrl.exe_cmd = CmdSbc;
                    OpAnd:   ctrl.exe_cmd = CmdAnd;
                    OpOrr:   ctrl.exe_cmd = CmdOrr;
                    OpEor:   ctrl.exe_cmd = CmdEor;
                    OpCmp: begin
                        ctrl.exe_cmd = CmdSub;
                        ctrl.wb_en   = 1'b0;
                    end
                    OpTst: begin
                        ctrl.exe_cmd = CmdAnd;
                        ctrl.wb_en   = 1'b0;
                    end
                    default: ctrl = '0;
                endcase
            end
            ModeMem: begin
                // Bit 20 selects load vs store; the address is always base + offset
                ctrl.exe_cmd = CmdAdd;
                ctrl.imm     = i_bit;
                if (s_bit) begin
                    ctrl.mem_r_en = 1'b1;
                    ctrl.wb_en    = 1'b1;
                end else begin
                    ctrl.mem_w_en = 1'b1;
                end
            end
            ModeBranch: ctrl.b = 1'b1;
            default:    ctrl = '0;
        endcase
    end

    // Stores read Rd as the data operand, so it replaces Rm as the second source
    assign src2    = ctrl.mem_w_en ? rd : rm;
    assign two_src = ~i_bit | ctrl.mem_w_en;

    // Stall request on a RAW dependency against EXE or MEM; branches read no registers
    always_comb begin
        hazard = ((rn == EXE_Dest) && EXE_WB_EN) || ((rn == MEM_Dest) && MEM_WB_EN) ||
                 (two_src && (((src2 == EXE_Dest) && EXE_WB_EN) ||
                              ((src2 == MEM_Dest) && MEM_WB_EN)));
        if (ctrl.b) begin
            hazard = 1'b0;
        end
    end

    // Failed condition suppresses side effects; a stall turns the slot into a bubble
    always_comb begin
        ctrl_g = ctrl;
        if (!cond_pass(Instruction[31:28], SR)) begin
            ctrl_g.wb_en    = 1'b0;
            ctrl_g.mem_r_en = 1'b0;
            ctrl_g.mem_w_en = 1'b0;
            ctrl_g.b        = 1'b0;
            ctrl_g.s        = 1'b0;
        end
        if (hazard) begin
            ctrl_g = '0;
        end
    end

    register_file u_register_file (
        .clk        (clk),
        .rst        (rst),
        .src1_i     (rn),
        .src2_i     (src2),
        .wr_en_i    (WB_WB_EN),
        .wr_dest_i  (WB_Dest),
        .wr_value_i (WB_Value),
        .rd1_o      (val_rn),
        .rd2_o      (val_rm)
    );

    // Next ID/EX contents; flush squashes the whole slot, overriding any stall
    always_comb begin
        out_d = '0;
        if (!flush) begin
            out_d.pc            = PC_in;
            out_d.val_rn        = val_rn;
            out_d.val_rm        = val_rm;
            out_d.dest          = rd;
            out_d.shift_operand = Instruction[11:0];
            out_d.signed_imm_24 = Instruction[23:0];
            out_d.ctrl          = ctrl_g;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign PC            = out_q.pc;
    assign Val_Rn        = out_q.val_rn;
    assign Val_Rm        = out_q.val_rm;
    assign Dest          = out_q.dest;
    assign EXE_CMD       = out_q.ctrl.exe_cmd;
    assign Shift_operand = out_q.shift_operand;
    assign Signed_imm_24 = out_q.signed_imm_24;
    assign WB_EN         = out_q.ctrl.wb_en;
    assign MEM_R_EN      = out_q.ctrl.mem_r_en;
    assign MEM_W_EN      = out_q.ctrl.mem_w_en;
    assign B             = out_q.ctrl.b;
    assign S             = out_q.ctrl.s;
    assign Imm           = out_q.ctrl.imm;

endmodule

// File: tb/tb_id_stage.sv
// Directed scoreboard bench for id_stage.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC_in, Instruction;
    logic        flush;
    logic [3:0]  SR;
    logic        WB_WB_EN;
    logic [3:0]  WB_Dest;
    logic [31:0] WB_Value;
    logic        EXE_WB_EN, MEM_WB_EN;
    logic [3:0]  EXE_Dest, MEM_Dest;
    logic        hazard;
    logic [31:0] PC, Val_Rn, Val_Rm;
    logic [3:0]  Dest, EXE_CMD;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm_24;
    logic        WB_EN, MEM_R_EN, MEM_W_EN, B, S, Imm;

    // ctl bits are {WB_EN, MEM_R_EN, MEM_W_EN, B, S, Imm}
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [3:0]  dest;
        logic [3:0]  cmd;
        logic [11:0] shift;
        logic [23:0] simm;
        logic [5:0]  ctl;
        logic        cmd_dc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] InsNop   = 32'hEC000000;
    localparam logic [31:0] InsAdd   = 32'hE0813002;
    localparam logic [31:0] InsAddI  = 32'hE2813002;
    localparam logic [31:0] InsB     = 32'hEA000001;
    localparam logic [31:0] InsMoveq = 32'h03A00001;
    localparam logic [31:0] InsStr   = 32'hE5812000;
    localparam logic [31:0] InsLdr   = 32'hE5912000;
    localparam logic [31:0] InsCmp   = 32'hE1510002;
    localparam logic [31:0] InsUndef = 32'hE0600000;
    localparam logic [31:0] InsAddR4 = 32'hE0845000;

    always #5 clk = ~clk;

    id_stage dut (
        .clk           (clk),
        .rst           (rst),
        .PC_in         (PC_in),
        .Instruction   (Instruction),
        .flush         (flush),
        .SR            (SR),
        .WB_WB_EN      (WB_WB_EN),
        .WB_Dest       (WB_Dest),
        .WB_Value      (WB_Value),
        .EXE_WB_EN     (EXE_WB_EN),
        .EXE_Dest      (EXE_Dest),
        .MEM_WB_EN     (MEM_WB_EN),
        .MEM_Dest      (MEM_Dest),
        .hazard        (hazard),
        .PC            (PC),
        .Val_Rn        (Val_Rn),
        .Val_Rm        (Val_Rm),
        .Dest          (Dest),
        .EXE_CMD       (EXE_CMD),
        .Shift_operand (Shift_operand),
        .Signed_imm_24 (Signed_imm_24),
        .WB_EN         (WB_EN),
        .MEM_R_EN      (MEM_R_EN),
        .MEM_W_EN      (MEM_W_EN),
        .B             (B),
        .S             (S),
        .Imm           (Imm)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] rn,
                                input logic [31:0] rm, input logic [3:0] dest,
                                input logic [3:0] cmd, input logic [31:0] instr,
                                input logic [5:0] ctl, input logic cmd_dc);
        exp_t e;
        e.pc     = pc;
        e.rn     = rn;
        e.rm     = rm;
        e.dest   = dest;
        e.cmd    = cmd;
        e.shift  = instr[11:0];
        e.simm   = instr[23:0];
        e.ctl    = ctl;
        e.cmd_dc = cmd_dc;
        return e;
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input exp_t e);
        PC_in       = pc;
        Instruction = instr;
        sb_q.push_back(e);
    endtask

    // Clock one edge, then pop the oldest expectation and compare the registered outputs
    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        check({tag, ".sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, ".pc"}, PC, e.pc);
            check({tag, ".val_rn"}, Val_Rn, e.rn);
            check({tag, ".val_rm"}, Val_Rm, e.rm);
            check({tag, ".dest"}, 32'(Dest), 32'(e.dest));
            if (!e.cmd_dc) check({tag, ".exe_cmd"}, 32'(EXE_CMD), 32'(e.cmd));
            check({tag, ".shift"}, 32'(Shift_operand), 32'(e.shift));
            check({tag, ".simm24"}, 32'(Signed_imm_24), 32'(e.simm));
            check({tag, ".ctl"}, 32'({WB_EN, MEM_R_EN, MEM_W_EN, B, S, Imm}), 32'(e.ctl));
        end
    endtask

    initial begin
        exp_t zero_e;
        zero_e = '0;

        // Reset, with a writeback attempt that reset must override
        rst = 1'b1; flush = 1'b0; SR = 4'b0000;
        WB_WB_EN = 1'b1; WB_Dest = 4'd5; WB_Value = 32'hDEAD_BEEF;
        EXE_WB_EN = 1'b0; EXE_Dest = 4'd0; MEM_WB_EN = 1'b0; MEM_Dest = 4'd0;
        drive(32'h4, InsAdd, zero_e);
        #1 check("reset.hazard", 32'(hazard), 32'd0);
        step("reset");
        rst = 1'b0; WB_WB_EN = 1'b0;

        // Every register reads zero after reset
        for (int r = 0; r < 16; r++) begin
            logic [31:0] ins;
            ins = 32'hE0800000 | (32'(r) << 16) | 32'(r);
            drive(32'h100 + 32'(r) * 4, ins, mk(32'h100 + 32'(r) * 4, 0, 0, 0, 4'd2, ins,
                                                6'b100000, 1'b0));
            step($sformatf("rd_r%0d", r));
        end

        // Write R1=5 then R2=7 under NOPs
        WB_WB_EN = 1'b1; WB_Dest = 4'd1; WB_Value = 32'd5;
        drive(32'h200, InsNop, mk(32'h200, 0, 0, 0, 4'd0, InsNop, 6'b000000, 1'b0));
        step("wr_r1");
        WB_Dest = 4'd2; WB_Value = 32'd7;
        drive(32'h204, InsNop, mk(32'h204, 0, 0, 0, 4'd0, InsNop, 6'b000000, 1'b0));
        step("wr_r2");
        WB_WB_EN = 1'b0;

        // ADD R3,R1,R2
        drive(32'h208, InsAdd, mk(32'h208, 5, 7, 3, 4'd2, InsAdd, 6'b100000, 1'b0));
        #1 check("add.hazard", 32'(hazard), 32'd0);
        step("add");

        // EXE dependency on Rn -> bubble
        EXE_Dest = 4'd1; EXE_WB_EN = 1'b1;
        drive(32'h20C, InsAdd, mk(32'h20C, 5, 7, 3, 4'd0, InsAdd, 6'b000000, 1'b0));
        #1 check("haz_exe.hazard", 32'(hazard), 32'd1);
        step("haz_exe");

        // MEM dependency on Rm -> bubble
        EXE_WB_EN = 1'b0; MEM_Dest = 4'd2; MEM_WB_EN = 1'b1;
        drive(32'h210, InsAdd, mk(32'h210, 5, 7, 3, 4'd0, InsAdd, 6'b000000, 1'b0));
        #1 check("haz_mem.hazard", 32'(hazard), 32'd1);
        step("haz_mem");

        // Immediate form has no second source, so the MEM match on Rm is ignored
        drive(32'h214, InsAddI, mk(32'h214, 5, 7, 3, 4'd2, InsAddI, 6'b100001, 1'b0));
        #1 check("haz_imm.hazard", 32'(hazard), 32'd0);
        step("haz_imm");
        MEM_WB_EN = 1'b0;

        // Dependency dropped -> normal ADD
        drive(32'h218, InsAdd, mk(32'h218, 5, 7, 3, 4'd2, InsAdd, 6'b100000, 1'b0));
        #1 check("nohaz.hazard", 32'(hazard), 32'd0);
        step("nohaz");

        // Branch never stalls even when its Rn field matches
        EXE_Dest = 4'd0; EXE_WB_EN = 1'b1;
        drive(32'h21C, InsB, mk(32'h21C, 0, 5, 0, 4'd0, InsB, 6'b000100, 1'b1));
        #1 check("branch.hazard", 32'(hazard), 32'd0);
        step("branch");
        EXE_WB_EN = 1'b0;

        // MOVEQ with Z=0 fails, with Z=1 executes
        SR = 4'b0000;
        drive(32'h220, InsMoveq, mk(32'h220, 0, 5, 0, 4'd1, InsMoveq, 6'b000001, 1'b0));
        step("moveq_z0");
        SR = 4'b0100;
        drive(32'h224, InsMoveq, mk(32'h224, 0, 5, 0, 4'd1, InsMoveq, 6'b100001, 1'b0));
        step("moveq_z1");
        SR = 4'b0000;

        // Flushed STR becomes all-zero
        flush = 1'b1;
        drive(32'h228, InsStr, zero_e);
        step("flush_str");
        flush = 1'b0;

        // STR reads Rd as second source
        drive(32'h22C, InsStr, mk(32'h22C, 5, 7, 2, 4'd2, InsStr, 6'b001000, 1'b0));
        #1 check("str.hazard", 32'(hazard), 32'd0);
        step("str");

        // Flush wins over a simultaneous hazard on the store data register
        EXE_Dest = 4'd2; EXE_WB_EN = 1'b1; flush = 1'b1;
        drive(32'h230, InsStr, zero_e);
        #1 check("flush_haz.hazard", 32'(hazard), 32'd1);
        step("flush_haz");
        EXE_WB_EN = 1'b0; flush = 1'b0;

        // LDR, CMP, undefined opcode
        drive(32'h234, InsLdr, mk(32'h234, 5, 0, 2, 4'd2, InsLdr, 6'b110000, 1'b0));
        step("ldr");
        drive(32'h238, InsCmp, mk(32'h238, 5, 7, 0, 4'd4, InsCmp, 6'b000010, 1'b0));
        step("cmp");
        drive(32'h23C, InsUndef, mk(32'h23C, 0, 0, 0, 4'd0, InsUndef, 6'b000000, 1'b0));
        step("undef");

        // Write-through: read R4 in the same cycle it is written, then from storage
        WB_WB_EN = 1'b1; WB_Dest = 4'd4; WB_Value = 32'hAB;
        drive(32'h240, InsAddR4, mk(32'h240, 32'hAB, 0, 5, 4'd2, InsAddR4, 6'b100000, 1'b0));
        step("wthru");
        WB_WB_EN = 1'b0;
        drive(32'h244, InsAddR4, mk(32'h244, 32'hAB, 0, 5, 4'd2, InsAddR4, 6'b100000, 1'b0));
        step("r4_stored");

        // Reset mid-stream discards the instruction; hazard stays combinational
        rst = 1'b1; EXE_Dest = 4'd1; EXE_WB_EN = 1'b1;
        drive(32'h248, InsAdd, zero_e);
        #1 check("rst_mid.hazard", 32'(hazard), 32'd1);
        step("rst_mid");
        rst = 1'b0; EXE_WB_EN = 1'b0;

        // Registers were cleared by that reset
        drive(32'h24C, InsAdd, mk(32'h24C, 0, 0, 3, 4'd2, InsAdd, 6'b100000, 1'b0));
        step("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
